// File: rtl/ndn_packet_rx.sv
// NDN byte-stream deframer: metadata, prefix and optional payload
// assembled into one packet and offered to the FIB with valid/ready.
module ndn_packet_rx #(
  parameter int PREFIX_BYTES   = 8,
  parameter int DATA_BYTES     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      data_ready,
  input  logic [7:0]                data_in,
  input  logic                      fib_ready,
  output logic                      pkt_valid,
  output logic                      pkt_is_data,
  output logic [8*PREFIX_BYTES-1:0] pkt_prefix,
  output logic [5:0]                pkt_prefix_len,
  output logic [8*DATA_BYTES-1:0]   pkt_data,
  output logic                      rx_busy,
  output logic                      rx_error
);

  localparam int PW = 8*PREFIX_BYTES;
  localparam int DW = 8*DATA_BYTES;
  localparam int IW = $clog2(TIMEOUT_CYCLES+1);

  typedef enum logic [1:0] {
    S_META,
    S_PREFIX,
    S_DATA,
    S_OUT
  } state_t;

  state_t state, state_next;

  logic          is_data_q;
  logic [5:0]    len_q;
  logic [PW-1:0] prefix_sr;
  logic [PW-1:0] prefix_out;
  logic [DW-1:0] data_sr;
  logic [5:0]    byte_cnt;
  logic [IW-1:0] idle_cnt;
  logic          err_q;

  logic          err_next;
  logic          last_byte;
  logic          load_out;
  logic [PW-1:0] pfx_src;
  logic [PW-1:0] pfx_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_META;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    last_byte  = 1'b0;
    unique case (state)
      S_META: begin
        if (data_ready) state_next = S_PREFIX;
      end
      S_PREFIX, S_DATA: begin
        if (data_ready) begin
          if (state == S_PREFIX)
            last_byte = (byte_cnt == 6'(PREFIX_BYTES-1));
          else
            last_byte = (byte_cnt == 6'(DATA_BYTES-1));
          if (last_byte) begin
            if (state == S_PREFIX && is_data_q) begin
              state_next = S_DATA;
            end else if (len_q == 6'd0) begin
              state_next = S_META;
              err_next   = 1'b1;
            end else begin
              state_next = S_OUT;
            end
          end
        end else if (idle_cnt == IW'(TIMEOUT_CYCLES-1)) begin
          state_next = S_META;
          err_next   = 1'b1;
        end
      end
      S_OUT: begin
        // bytes here are overruns and are dropped
        err_next = data_ready;
        if (fib_ready) state_next = S_META;
      end
      default: state_next = S_META;
    endcase
  end

  assign load_out = (state_next == S_OUT) && (state != S_OUT);
  assign pfx_src  = (state == S_PREFIX) ?
                    {prefix_sr[PW-9:0], data_in} : prefix_sr;
  assign pfx_mask = (PW'(1) << len_q) - PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_data_q  <= 1'b0;
      len_q      <= '0;
      prefix_sr  <= '0;
      prefix_out <= '0;
      data_sr    <= '0;
      byte_cnt   <= '0;
      idle_cnt   <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_next;
      if (load_out) prefix_out <= pfx_src & pfx_mask;
      case (state)
        S_META: begin
          idle_cnt <= '0;
          if (data_ready) begin
            is_data_q <= data_in[7];
            len_q     <= data_in[5:0];
            prefix_sr <= '0;
            data_sr   <= '0;
            byte_cnt  <= '0;
          end
        end
        S_PREFIX, S_DATA: begin
          if (data_ready) begin
            if (state == S_PREFIX)
              prefix_sr <= {prefix_sr[PW-9:0], data_in};
            else
              data_sr <= {data_sr[DW-9:0], data_in};
            byte_cnt <= last_byte ? 6'd0 : byte_cnt + 6'd1;
            idle_cnt <= '0;
          end else if (state_next != state) begin
            idle_cnt <= '0;
          end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: idle_cnt <= '0;
      endcase
    end
  end

  assign pkt_valid      = (state == S_OUT);
  assign pkt_is_data    = is_data_q;
  assign pkt_prefix     = prefix_out;
  assign pkt_prefix_len = len_q;
  assign pkt_data       = data_sr;
  assign rx_busy        = (state != S_META);
  assign rx_error       = err_q;

endmodule
